// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets several requesters share one UART transmitter.
// It captures the winner's byte, launches a frame, and watches tx_busy for the handshake and the timeout.
module uart_tx_arbiter #(
   parameter int NREQ      = 4,
   parameter int DATAWIDTH = 8,
   parameter int TIMEOUT   = 4
) (
   input  logic                      baud_clk,
   input  logic                      reset_n,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ*DATAWIDTH-1:0] req_data,
   output logic [NREQ-1:0]           gnt,
   output logic [DATAWIDTH-1:0]      tx_data,
   output logic                      tx_start,
   input  logic                      tx_busy,
   output logic [$clog2(NREQ)-1:0]   tx_owner,
   output logic                      frame_done,
   output logic                      tx_err
);

   localparam int OW = $clog2(NREQ);
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_BUSY,
      WAIT_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [OW-1:0]         ptr_q, ptr_d;
   logic [NREQ-1:0]       gnt_q, gnt_d;
   logic [DATAWIDTH-1:0]  tx_data_q, tx_data_d;
   logic                  tx_start_q, tx_start_d;
   logic [OW-1:0]         tx_owner_q, tx_owner_d;
   logic                  frame_done_q, frame_done_d;
   logic                  tx_err_q, tx_err_d;

   logic                  found;
   logic [OW-1:0]         win;
   logic [OW-1:0]         cand;

   // Search starts just past the last winner, so the most recent owner has lowest priority.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = OW'((int'(ptr_q) + k) % NREQ);
         if (!found && req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      ptr_d        = ptr_q;
      gnt_d        = '0;
      tx_data_d    = tx_data_q;
      tx_start_d   = 1'b0;
      tx_owner_d   = tx_owner_q;
      frame_done_d = 1'b0;
      tx_err_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (found && !tx_busy) begin
               gnt_d[win] = 1'b1;
               tx_data_d  = req_data[win*DATAWIDTH +: DATAWIDTH];
               tx_start_d = 1'b1;
               tx_owner_d = win;
               ptr_d      = win;
               cnt_d      = '0;
               state_d    = WAIT_BUSY;
            end
         end
         WAIT_BUSY: begin
            if (tx_busy) begin
               cnt_d   = '0;
               state_d = WAIT_DONE;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               // The counter's final step lands on TIMEOUT, so the error is flagged and the count restarts.
               cnt_d    = '0;
               tx_err_d = 1'b1;
               state_d  = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               frame_done_d = 1'b1;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge baud_clk or posedge reset_n) begin
      if (reset_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         ptr_q        <= OW'(NREQ - 1);
         gnt_q        <= '0;
         tx_data_q    <= '0;
         tx_start_q   <= 1'b0;
         tx_owner_q   <= '0;
         frame_done_q <= 1'b0;
         tx_err_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         ptr_q        <= ptr_d;
         gnt_q        <= gnt_d;
         tx_data_q    <= tx_data_d;
         tx_start_q   <= tx_start_d;
         tx_owner_q   <= tx_owner_d;
         frame_done_q <= frame_done_d;
         tx_err_q     <= tx_err_d;
      end
   end

   assign gnt        = gnt_q;
   assign tx_data    = tx_data_q;
   assign tx_start   = tx_start_q;
   assign tx_owner   = tx_owner_q;
   assign frame_done = frame_done_q;
   assign tx_err     = tx_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a vector table of single grants, then hand-written rotation, timeout,
// busy-blocking and mid-frame reset sequences, with grants checked against a queue of expected grants.
module tb_uart_tx_arbiter;

   logic        baud_clk;
   logic        reset_n;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  gnt;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_busy;
   logic [1:0]  tx_owner;
   logic        frame_done;
   logic        tx_err;

   logic        model_en;
   logic        busy_man;
   int          busy_cnt;

   typedef struct {
      logic [3:0]  req;
      logic [31:0] data;
      logic [3:0]  exp_gnt;
      logic [7:0]  exp_data;
      logic [1:0]  exp_owner;
   } vec_t;

   typedef struct {
      logic [3:0] gnt;
      logic [7:0] data;
      logic [1:0] owner;
   } exp_t;

   exp_t exp_q[$];
   vec_t vecs[9];

   int n_cmp;
   int n_err;
   int fd_count;
   int err_count;
   int viol;

   uart_tx_arbiter #(.NREQ(4), .DATAWIDTH(8), .TIMEOUT(4)) dut (
      .baud_clk   (baud_clk),
      .reset_n    (reset_n),
      .req        (req),
      .req_data   (req_data),
      .gnt        (gnt),
      .tx_data    (tx_data),
      .tx_start   (tx_start),
      .tx_busy    (tx_busy),
      .tx_owner   (tx_owner),
      .frame_done (frame_done),
      .tx_err     (tx_err)
   );

   initial baud_clk = 1'b0;
   always #5 baud_clk = ~baud_clk;

   // Transmitter model: busy for ten cycles after every tx_start it sees.
   always @(posedge baud_clk) begin
      if (!model_en)
         busy_cnt <= 0;
      else if (tx_start)
         busy_cnt <= 10;
      else if (busy_cnt != 0)
         busy_cnt <= busy_cnt - 1;
   end

   assign tx_busy = model_en ? (busy_cnt != 0) : busy_man;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input logic [3:0] r, input logic [31:0] d);
      req      = r;
      req_data = d;
   endtask

   task automatic push_exp(input logic [3:0] g, input logic [7:0] d, input logic [1:0] o);
      exp_t e;
      e.gnt   = g;
      e.data  = d;
      e.owner = o;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      @(negedge baud_clk);
      reset_n = 1'b1;
      repeat (2) @(negedge baud_clk);
      reset_n = 1'b0;
   endtask

   // Called on the negedge where the grant is visible; runs a short frame by hand.
   task automatic finish_frame();
      int fd0;
      fd0 = fd_count;
      @(negedge baud_clk);
      busy_man = 1'b1;
      repeat (3) @(negedge baud_clk);
      busy_man = 1'b0;
      repeat (2) @(negedge baud_clk);
      check_output("frame_done per frame", fd_count - fd0, 1);
      check_output("pending grants", exp_q.size(), 0);
      exp_q.delete();
   endtask

   // Grant monitor: every observed grant must match the oldest expected one.
   always @(negedge baud_clk) begin
      exp_t e;
      if (gnt != 4'b0) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("[TB] FAIL unexpected grant: got gnt=%b, required none", gnt);
         end else begin
            e = exp_q.pop_front();
            check_output("gnt", 32'(gnt), 32'(e.gnt));
            check_output("tx_data", 32'(tx_data), 32'(e.data));
            check_output("tx_owner", 32'(tx_owner), 32'(e.owner));
            check_output("tx_start with gnt", 32'(tx_start), 32'd1);
         end
      end
      if (frame_done) fd_count++;
      if (tx_err) err_count++;
      if (gnt != 4'b0 && frame_done) viol++;
      if (tx_start && tx_busy) viol++;
      if ($countones(gnt) > 1) viol++;
      if (tx_start != (gnt != 4'b0)) viol++;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int fd0;
      int e0;
      int seen;

      n_cmp = 0; n_err = 0; fd_count = 0; err_count = 0; viol = 0;
      reset_n  = 1'b1;
      model_en = 1'b0;
      busy_man = 1'b0;
      apply_stimulus(4'b0, 32'h0);

      // Expected values derived by hand from the round-robin pointer, which starts at 3.
      vecs[0] = '{4'b0100, 32'h33A5_1100, 4'b0100, 8'hA5, 2'd2};
      vecs[1] = '{4'b1001, 32'h4D00_00E1, 4'b1000, 8'h4D, 2'd3};
      vecs[2] = '{4'b0011, 32'h0000_7C6B, 4'b0001, 8'h6B, 2'd0};
      vecs[3] = '{4'b1101, 32'h9F8E_0012, 4'b0100, 8'h8E, 2'd2};
      vecs[4] = '{4'b0001, 32'h0000_0055, 4'b0001, 8'h55, 2'd0};
      vecs[5] = '{4'b0001, 32'h0000_00AA, 4'b0001, 8'hAA, 2'd0};
      vecs[6] = '{4'b1010, 32'h3C00_C300, 4'b0010, 8'hC3, 2'd1};
      vecs[7] = '{4'b0011, 32'h0000_F00F, 4'b0001, 8'h0F, 2'd0};
      vecs[8] = '{4'b1110, 32'h8040_2000, 4'b0010, 8'h20, 2'd1};

      repeat (3) @(negedge baud_clk);
      check_output("reset gnt", 32'(gnt), 32'd0);
      check_output("reset tx_data", 32'(tx_data), 32'd0);
      check_output("reset tx_start", 32'(tx_start), 32'd0);
      check_output("reset tx_owner", 32'(tx_owner), 32'd0);
      check_output("reset frame_done", 32'(frame_done), 32'd0);
      check_output("reset tx_err", 32'(tx_err), 32'd0);
      reset_n = 1'b0;

      for (int i = 0; i < 9; i++) begin
         @(negedge baud_clk);
         apply_stimulus(vecs[i].req, vecs[i].data);
         push_exp(vecs[i].exp_gnt, vecs[i].exp_data, vecs[i].exp_owner);
         @(negedge baud_clk);
         check_output($sformatf("vec%0d gnt latency", i), 32'(gnt), 32'(vecs[i].exp_gnt));
         apply_stimulus(4'b0, 32'h0);
         finish_frame();
      end

      $display("[TB] rotation with all requesters active");
      do_reset();
      @(negedge baud_clk);
      model_en = 1'b1;
      push_exp(4'b0001, 8'hAA, 2'd0);
      push_exp(4'b0010, 8'hBB, 2'd1);
      push_exp(4'b0100, 8'hCC, 2'd2);
      push_exp(4'b1000, 8'hDD, 2'd3);
      push_exp(4'b0001, 8'hAA, 2'd0);
      fd0 = fd_count;
      apply_stimulus(4'b1111, 32'hDDCC_BBAA);
      seen = 0;
      for (int c = 0; c < 400 && seen < 5; c++) begin
         @(negedge baud_clk);
         if (gnt != 4'b0) seen++;
      end
      apply_stimulus(4'b0, 32'h0);
      check_output("rotation grant count", seen, 5);
      for (int c = 0; c < 100 && (fd_count - fd0) < 5; c++) @(negedge baud_clk);
      check_output("rotation frame_done count", fd_count - fd0, 5);
      check_output("rotation pending grants", exp_q.size(), 0);
      exp_q.delete();
      repeat (2) @(negedge baud_clk);
      model_en = 1'b0;
      repeat (2) @(negedge baud_clk);

      $display("[TB] timeout with tx_busy held low");
      e0 = err_count;
      apply_stimulus(4'b0010, 32'h0000_6600);
      push_exp(4'b0010, 8'h66, 2'd1);
      @(negedge baud_clk);
      check_output("timeout tx_start", 32'(tx_start), 32'd1);
      req_data = 32'h0000_7700;
      push_exp(4'b0010, 8'h77, 2'd1);
      for (int i = 2; i <= 4; i++) begin
         @(negedge baud_clk);
         check_output($sformatf("no tx_err cycle %0d", i - 1), 32'(tx_err), 32'd0);
      end
      @(negedge baud_clk);
      check_output("tx_err on 4th cycle", 32'(tx_err), 32'd1);
      check_output("no gnt with tx_err", 32'(gnt), 32'd0);
      @(negedge baud_clk);
      check_output("regrant after timeout", 32'(gnt), 32'b0010);
      apply_stimulus(4'b0, 32'h0);
      for (int c = 0; c < 12 && (err_count - e0) < 2; c++) @(negedge baud_clk);
      check_output("tx_err pulse count", err_count - e0, 2);
      check_output("timeout pending grants", exp_q.size(), 0);
      exp_q.delete();
      repeat (2) @(negedge baud_clk);

      $display("[TB] external tx_busy blocks grant in IDLE");
      busy_man = 1'b1;
      apply_stimulus(4'b0001, 32'h0000_003E);
      for (int i = 0; i < 4; i++) begin
         @(negedge baud_clk);
         check_output($sformatf("blocked gnt %0d", i), 32'(gnt), 32'd0);
      end
      busy_man = 1'b0;
      push_exp(4'b0001, 8'h3E, 2'd0);
      @(negedge baud_clk);
      check_output("gnt after busy falls", 32'(gnt), 32'b0001);
      apply_stimulus(4'b0, 32'h0);
      finish_frame();

      $display("[TB] reset during WAIT_DONE");
      @(negedge baud_clk);
      apply_stimulus(4'b0010, 32'h0000_5A00);
      push_exp(4'b0010, 8'h5A, 2'd1);
      @(negedge baud_clk);
      apply_stimulus(4'b0, 32'h0);
      @(negedge baud_clk);
      busy_man = 1'b1;
      repeat (2) @(negedge baud_clk);
      fd0 = fd_count;
      #2 reset_n = 1'b1;
      #1;
      check_output("abort gnt", 32'(gnt), 32'd0);
      check_output("abort tx_data", 32'(tx_data), 32'd0);
      check_output("abort tx_start", 32'(tx_start), 32'd0);
      check_output("abort tx_owner", 32'(tx_owner), 32'd0);
      check_output("abort frame_done", 32'(frame_done), 32'd0);
      check_output("abort tx_err", 32'(tx_err), 32'd0);
      @(negedge baud_clk);
      busy_man = 1'b0;
      repeat (2) @(negedge baud_clk);
      check_output("no frame_done after abort", fd_count - fd0, 0);
      reset_n = 1'b0;
      @(negedge baud_clk);
      apply_stimulus(4'b1000, 32'hC900_0000);
      push_exp(4'b1000, 8'hC9, 2'd3);
      @(negedge baud_clk);
      check_output("grant 3 after reset", 32'(gnt), 32'b1000);
      apply_stimulus(4'b0, 32'h0);
      finish_frame();

      check_output("protocol violations", viol, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the transmitter (2..8).
REQ-002 Parameter DATAWIDTH, default 8, byte width per requester.
REQ-003 Parameter TIMEOUT, default 4, baud_clk cycles allowed between tx_start and tx_busy rising.
REQ-004 baud_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-high reset (asserted = 1).
REQ-006 req  input  NREQ  per-requester transmit request, level, held until granted.
REQ-007 req_data  input  NREQ*DATAWIDTH  byte for requester i on bits [i*DATAWIDTH +: DATAWIDTH].
REQ-008 gnt  output  NREQ  one-hot, one-cycle pulse: requester's byte captured.
REQ-009 tx_data  output  DATAWIDTH  registered byte presented to the UART transmitter.
REQ-010 tx_start  output  1  one-cycle pulse launching a frame.
REQ-011 tx_busy  input  1  high while the transmitter is sending a frame.
REQ-012 tx_owner  output  clog2(NREQ)  index of the requester owning the current or last frame.
REQ-013 frame_done  output  1  one-cycle pulse when the owned frame completes.
REQ-014 tx_err  output  1  one-cycle pulse when tx_busy fails to rise within TIMEOUT cycles.

Function
REQ-015 The FSM SHALL have the states IDLE, WAIT_BUSY and WAIT_DONE.
REQ-016 In IDLE with req != 0 and tx_busy = 0, the block SHALL grant on the next edge: gnt[w] = 1, tx_data = slice w, tx_start = 1, tx_owner = w, state -> WAIT_BUSY.
REQ-017 In IDLE with tx_busy = 1, no grant SHALL issue; the block stays in IDLE.
REQ-018 Winner w SHALL be the first asserted req searching ptr+1, ptr+2, ... modulo NREQ, where ptr is the last granted index.
REQ-019 ptr SHALL update to w on the grant edge.
REQ-020 gnt, tx_start, frame_done and tx_err SHALL each be high for exactly one cycle per event and otherwise 0.
REQ-021 WAIT_BUSY: when tx_busy = 1, the state SHALL go to WAIT_DONE and the timeout counter SHALL clear.
REQ-022 WAIT_BUSY: otherwise the counter SHALL increment; when it reaches TIMEOUT, the block SHALL pulse tx_err, return to IDLE and clear the counter.
REQ-023 WAIT_DONE: when tx_busy = 0, the block SHALL pulse frame_done and go to IDLE.
REQ-024 tx_data and tx_owner SHALL hold stable from grant until the next grant.
REQ-025 req changes outside IDLE SHALL be ignored; a requester may drop req before grant without effect.
REQ-026 After a gnt, the requester may present a new byte with req high on the following cycle; it competes normally.
REQ-027 A grant SHALL never occur in the same cycle as frame_done; IDLE lasts at least one cycle between frames.
REQ-028 With all NREQ requesters continuously requesting, grants SHALL rotate 0,1,...,NREQ-1,0; no requester waits more than NREQ-1 frames.
REQ-029 Latency from req assertion in IDLE (tx_busy = 0) to gnt/tx_start SHALL be exactly one cycle.

Reset
REQ-030 reset_n = 1 SHALL asynchronously force state IDLE, counter 0, ptr NREQ-1, gnt 0, tx_data 0, tx_start 0, tx_owner 0, frame_done 0 and tx_err 0.
REQ-031 Reset mid-frame SHALL abort ownership silently, with no frame_done or tx_err pulse.
REQ-032 The first grant after reset SHALL resolve requester 0 highest.

Verification
REQ-033 Reset, then req = 4'b0100 with data2 = 8'hA5 and tx_busy low -> next cycle gnt = 4'b0100, tx_data = 8'hA5, tx_start = 1, tx_owner = 2.
REQ-034 req = 4'b1111 held, transmitter model busy 10 cycles per frame -> gnt order 0,1,2,3,0; frame_done once per frame; tx_start never during tx_busy.
REQ-035 Grant to requester 1, tx_busy held low -> tx_err pulses on the 4th cycle after tx_start; then IDLE, and a pending req is regranted next cycle.
REQ-036 tx_busy high externally in IDLE with req = 4'b0001 -> no gnt until tx_busy falls, then gnt the following cycle.
REQ-037 reset_n asserted during WAIT_DONE -> all outputs 0 immediately, no frame_done; after release req = 4'b1000 -> grant 3.
